// File: rtl/fifo_wr_arbiter_if.sv
// Requester-stream and FIFO write-port bundle for fifo_wr_arbiter.
// The master side is the producers plus the FIFO full flag. The slave side is the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int N  = 4,
  parameter int DW = 64
);
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_wen;
  logic [DW-1:0]   fifo_wdata;

  modport master (
    output req_valid, req_last, req_data, fifo_full,
    input  req_ready, fifo_wen, fifo_wdata
  );

  modport slave (
    input  req_valid, req_last, req_data, fifo_full,
    output req_ready, fifo_wen, fifo_wdata
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the single write port of the write-side async FIFO.
// A grant is registered, so there is one cycle of arbitration and one dead cycle
// between bursts. Beats are passed through combinationally while a grant is held.
module fifo_wr_arbiter #(
  parameter int  N         = 4,
  parameter int  DW        = 64,
  parameter int  MAX_BURST = 4,
  localparam int IDXW      = $clog2(N)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  fifo_wr_arbiter_if.slave bus,
  output logic [IDXW-1:0]  grant_idx,
  output logic             busy,
  output logic [7:0]       beat_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [IDXW-1:0] grant_d;
  logic [IDXW-1:0] rr_ptr;
  logic [IDXW-1:0] rr_ptr_d;
  logic [7:0]      beat_cnt_d;
  logic [IDXW-1:0] pick_idx;
  logic            pick_found;
  logic            g_valid;
  logic            g_last;
  logic            beat;
  logic            burst_end;
  int              cand;

  // Round-robin search starting just after the last serviced requester; the
  // modulo wrap keeps the search inside 0..N-1 for any N.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(rr_ptr) + k) % N;
      if (!pick_found && bus.req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = IDXW'(cand);
      end
    end
  end

  // Beat qualification and the write-port mux; a full FIFO stalls without a beat.
  always_comb begin
    g_valid        = bus.req_valid[grant_idx];
    g_last         = bus.req_last[grant_idx];
    beat           = (state_q == GRANT) && g_valid && !bus.fifo_full;
    burst_end      = g_last || (beat_cnt == 8'(MAX_BURST - 1));
    bus.fifo_wen   = beat;
    bus.req_ready  = beat ? (N'(1) << grant_idx) : '0;
    bus.fifo_wdata = (state_q == GRANT) ? bus.req_data[int'(grant_idx) * DW +: DW] : '0;
  end

  // Next-state logic: start a grant from IDLE, end it on last, burst limit or drop.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_idx;
    rr_ptr_d   = rr_ptr;
    beat_cnt_d = beat_cnt;
    unique case (state_q)
      IDLE: begin
        if (en && pick_found) begin
          state_d    = GRANT;
          grant_d    = pick_idx;
          beat_cnt_d = 8'd0;
        end
      end
      GRANT: begin
        if (beat) begin
          beat_cnt_d = beat_cnt + 8'd1;
          if (burst_end) begin
            state_d  = IDLE;
            rr_ptr_d = grant_idx;
          end
        end else if (!g_valid) begin
          state_d  = IDLE;
          rr_ptr_d = grant_idx;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and grant registers. The round-robin pointer resets to N-1 so requester 0 goes first.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      grant_idx <= '0;
      rr_ptr    <= IDXW'(N - 1);
      beat_cnt  <= 8'd0;
    end else begin
      state_q   <= state_d;
      grant_idx <= grant_d;
      rr_ptr    <= rr_ptr_d;
      beat_cnt  <= beat_cnt_d;
    end
  end

  assign busy = (state_q == GRANT);

endmodule
